// File: rtl/iiitb_tlc_pkg.sv
// Shared encodings for the farm-road sensor conditioner and the traffic light controller.
package iiitb_tlc_pkg;

    typedef enum logic [1:0] {
        StHold   = 2'b00,
        StIdle   = 2'b01,
        StReq    = 2'b10,
        StServed = 2'b11
    } tlc_state_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [7:0] REQ_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/iiitb_tlc_debounce.sv
// Synchroniser chain followed by a debounce counter that flips the clean level only after
// DEBOUNCE_CYCLES consecutive samples disagree with it.
module iiitb_tlc_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_raw,
    output logic sensor_db
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sensor_sync;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
        end
    end

    assign sensor_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sensor_sync != db_q) begin
            if (cnt_q == DB_LAST) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign sensor_db = db_q;

endmodule

// File: rtl/iiitb_tlc_sensor_cond.sv
// Farm-road sensor conditioner: debounced arrivals become a sticky request held until served,
// with a minimum highway-green hold. Optional arrival counter under TLC_REQ_COUNT_EN.
module iiitb_tlc_sensor_cond
    import iiitb_tlc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned DEBOUNCE_CYCLES  = 16,
    parameter int unsigned MIN_GREEN_CYCLES = 64,
    parameter int unsigned CNT_W            = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       sensor_raw,
    input  logic       farm_green_ack,
    output logic       req_o,
    output logic       sensor_db,
    output logic       hold_active,
    output logic [7:0] req_count
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_GREEN_CYCLES - 1);

    logic             sensor_db_d;
    logic             rise;
    logic             pending_q, pending_d;
    tlc_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    iiitb_tlc_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .sensor_raw(sensor_raw),
        .sensor_db (sensor_db)
    );

    assign rise = sensor_db & ~sensor_db_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        pending_d = pending_q;
        unique case (state_q)
            StHold: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = pending_q ? StReq : StIdle;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            StIdle: begin
                if (pending_q) state_d = StReq;
            end
            StReq: begin
                if (farm_green_ack) begin
                    state_d   = StServed;
                    pending_d = 1'b0;
                end
            end
            StServed: begin
                if (!farm_green_ack) state_d = StHold;
            end
            default: state_d = StHold;
        endcase
        // A fresh arrival outranks the clear issued by the service handshake.
        if (rise) pending_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StHold;
            timer_q     <= '0;
            pending_q   <= 1'b0;
            sensor_db_d <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            sensor_db_d <= sensor_db;
        end
    end

    assign req_o       = (state_q == StReq);
    assign hold_active = (state_q == StHold);

`ifdef TLC_REQ_COUNT_EN
    logic [7:0] req_count_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_count_q <= 8'd0;
        end else if (rise && (req_count_q != REQ_COUNT_MAX)) begin
            req_count_q <= req_count_q + 8'd1;
        end
    end

    assign req_count = req_count_q;
`else
    assign req_count = 8'd0;
`endif

endmodule

// File: tb/tb_iiitb_tlc_sensor_cond.sv
// Directed bench for iiitb_tlc_sensor_cond with SYNC=2, DEBOUNCE=4, MIN_GREEN=8.
module tb_iiitb_tlc_sensor_cond;

`ifdef TLC_REQ_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_raw;
    logic       farm_green_ack;
    logic       req_o;
    logic       sensor_db;
    logic       hold_active;
    logic [7:0] req_count;

    int checks = 0;
    int fails  = 0;

    iiitb_tlc_sensor_cond #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .MIN_GREEN_CYCLES(8),
        .CNT_W           (16)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .sensor_raw    (sensor_raw),
        .farm_green_ack(farm_green_ack),
        .req_o         (req_o),
        .sensor_db     (sensor_db),
        .hold_active   (hold_active),
        .req_count     (req_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_count(input int n);
        return COUNT_EN ? 8'(n) : 8'd0;
    endfunction

    initial begin
        rst            = 1'b1;
        sensor_raw     = 1'b0;
        farm_green_ack = 1'b0;
        step(2);
        check("rst_req", {7'd0, req_o}, 8'd0);
        check("rst_db", {7'd0, sensor_db}, 8'd0);
        check("rst_hold", {7'd0, hold_active}, 8'd1);
        check("rst_count", req_count, 8'd0);

        // Hold after reset: the reset edge plus 7 more cycles, then IDLE.
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("hold_on", {7'd0, hold_active}, 8'd1);
            check("hold_req", {7'd0, req_o}, 8'd0);
        end
        step(1);
        check("hold_end", {7'd0, hold_active}, 8'd0);
        check("hold_end_req", {7'd0, req_o}, 8'd0);

        // Glitch of 3 cycles never reaches the debounced level.
        sensor_raw = 1'b1;
        step(3);
        sensor_raw = 1'b0;
        step(8);
        check("glitch_db", {7'd0, sensor_db}, 8'd0);
        check("glitch_req", {7'd0, req_o}, 8'd0);
        check("glitch_count", req_count, 8'd0);

        // Ack outside REQ/SERVED is ignored.
        farm_green_ack = 1'b1;
        step(2);
        farm_green_ack = 1'b0;
        step(1);
        check("ack_idle_req", {7'd0, req_o}, 8'd0);
        check("ack_idle_hold", {7'd0, hold_active}, 8'd0);

        // Clean arrival.
        sensor_raw = 1'b1;
        step(5);
        check("arr_db_early", {7'd0, sensor_db}, 8'd0);
        step(1);
        check("arr_db", {7'd0, sensor_db}, 8'd1);
        step(1);
        check("arr_req_early", {7'd0, req_o}, 8'd0);
        step(1);
        check("arr_req", {7'd0, req_o}, 8'd1);
        check("arr_count", req_count, exp_count(1));

        // Falling debounced level leaves the request latched.
        sensor_raw = 1'b0;
        step(8);
        check("fall_db", {7'd0, sensor_db}, 8'd0);
        check("fall_req", {7'd0, req_o}, 8'd1);

        // Service handshake: ack high for 5 cycles.
        farm_green_ack = 1'b1;
        step(1);
        check("srv_req_drop", {7'd0, req_o}, 8'd0);
        check("srv_no_hold", {7'd0, hold_active}, 8'd0);
        step(4);
        check("srv_still", {7'd0, hold_active}, 8'd0);
        farm_green_ack = 1'b0;
        step(1);
        check("srv_hold", {7'd0, hold_active}, 8'd1);

        // New arrival during the hold is presented only when the hold ends.
        sensor_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("hreq_hold", {7'd0, hold_active}, 8'd1);
            check("hreq_req", {7'd0, req_o}, 8'd0);
        end
        step(1);
        check("hreq_req_up", {7'd0, req_o}, 8'd1);
        check("hreq_hold_dn", {7'd0, hold_active}, 8'd0);
        check("hreq_count", req_count, exp_count(2));

        // Serve it; with no new arrival the hold ends in IDLE.
        farm_green_ack = 1'b1;
        step(1);
        check("srv2_req", {7'd0, req_o}, 8'd0);
        farm_green_ack = 1'b0;
        step(1);
        check("srv2_hold", {7'd0, hold_active}, 8'd1);
        step(8);
        check("srv2_idle_hold", {7'd0, hold_active}, 8'd0);
        check("srv2_idle_req", {7'd0, req_o}, 8'd0);

        // 260 further arrivals saturate the counter.
        for (int n = 0; n < 260; n++) begin
            sensor_raw = 1'b0;
            step(7);
            sensor_raw = 1'b1;
            step(7);
        end
        check("sat_count", req_count, exp_count(255));
        check("sat_req", {7'd0, req_o}, 8'd1);

        // Reset mid-operation.
        rst = 1'b1;
        step(1);
        check("mid_rst_req", {7'd0, req_o}, 8'd0);
        check("mid_rst_db", {7'd0, sensor_db}, 8'd0);
        check("mid_rst_hold", {7'd0, hold_active}, 8'd1);
        check("mid_rst_count", req_count, 8'd0);
        rst = 1'b0;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
